// File: rtl/alu_control_mc.sv
// alu_control_mc: ALU control decoder with a multi-cycle MULT sequencer.
// The decoder turns alu_op plus the R-type funct into an ALU operation code.
// The sequencer stalls the pipeline and holds the MULT code while the
// iterative multiplier is running. It pulses mult_start on issue and
// mult_done when the result may be written back.
module alu_control_mc #(
  parameter int FUNCT_W     = 6,
  parameter int ALU_CTRL_W  = 4,
  parameter int MULT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  in_valid,
  input  logic                  flush,
  input  logic [1:0]            alu_op,
  input  logic [FUNCT_W-1:0]    function_field,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  stall,
  output logic                  mult_start,
  output logic                  mult_done,
  output logic                  illegal_op,
  output logic                  illegal_seen
);

  // ALU operation codes, zero-extended to the control width.
  localparam logic [ALU_CTRL_W-1:0] C_AND  = ALU_CTRL_W'(4'd0);
  localparam logic [ALU_CTRL_W-1:0] C_OR   = ALU_CTRL_W'(4'd1);
  localparam logic [ALU_CTRL_W-1:0] C_ADD  = ALU_CTRL_W'(4'd2);
  localparam logic [ALU_CTRL_W-1:0] C_SLL  = ALU_CTRL_W'(4'd3);
  localparam logic [ALU_CTRL_W-1:0] C_SRL  = ALU_CTRL_W'(4'd4);
  localparam logic [ALU_CTRL_W-1:0] C_SUB  = ALU_CTRL_W'(4'd5);
  localparam logic [ALU_CTRL_W-1:0] C_SLT  = ALU_CTRL_W'(4'd7);
  localparam logic [ALU_CTRL_W-1:0] C_NOR  = ALU_CTRL_W'(4'd12);
  localparam logic [ALU_CTRL_W-1:0] C_MULT = ALU_CTRL_W'(4'd14);

  // R-type funct encodings.
  localparam logic [FUNCT_W-1:0] F_ADD  = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB  = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_AND  = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR   = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_NOR  = FUNCT_W'(6'b100111);
  localparam logic [FUNCT_W-1:0] F_SLT  = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] F_SLL  = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] F_SRL  = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] F_MULT = FUNCT_W'(6'b011000);

  // alu_op encodings from the main control unit.
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_SLT   = 2'b11;

  // A single-cycle multiplier finishes in its issue cycle and needs no BUSY state.
  localparam bit SINGLE_CYCLE = (MULT_CYCLES == 1);

  // The counter holds the number of BUSY cycles left before the done cycle.
  // It never exceeds MULT_CYCLES-2.
  localparam int CNT_W = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (MULT_CYCLES > 1) ? CNT_W'(MULT_CYCLES - 2) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  logic [CNT_W-1:0] cnt;

  logic [ALU_CTRL_W-1:0] funct_code;
  logic                  funct_ok;
  logic [ALU_CTRL_W-1:0] decode_code;
  logic                  mult_issue;
  logic                  cnt_zero;

  // Funct-field map. Unsupported encodings yield code 0 and are flagged.
  always_comb begin
    funct_code = '0;
    funct_ok   = 1'b1;
    case (function_field)
      F_ADD:   funct_code = C_ADD;
      F_SUB:   funct_code = C_SUB;
      F_AND:   funct_code = C_AND;
      F_OR:    funct_code = C_OR;
      F_NOR:   funct_code = C_NOR;
      F_SLT:   funct_code = C_SLT;
      F_SLL:   funct_code = C_SLL;
      F_SRL:   funct_code = C_SRL;
      F_MULT:  funct_code = C_MULT;
      default: begin
        funct_code = '0;
        funct_ok   = 1'b0;
      end
    endcase
  end

  // alu_op map. Only R-type instructions consult the funct field.
  always_comb begin
    decode_code = C_ADD;
    case (alu_op)
      OP_ADD:   decode_code = C_ADD;
      OP_SUB:   decode_code = C_SUB;
      OP_RTYPE: decode_code = funct_code;
      OP_SLT:   decode_code = C_SLT;
      default:  decode_code = C_ADD;
    endcase
  end

  assign illegal_op = in_valid & (alu_op == OP_RTYPE) & ~funct_ok;

  // A MULT may only launch from IDLE. The issue term is masked while reset is
  // held, so the pulses stay low even if a MULT sits on the inputs.
  assign mult_issue = in_valid & ~flush & ~arst & (state == IDLE) &
                      (alu_op == OP_RTYPE) & (function_field == F_MULT);

  assign cnt_zero = (cnt == '0);

  // Output generation. In BUSY the MULT code is held and the inputs are ignored.
  // flush silences both stall and done in the cycle that aborts the operation.
  always_comb begin
    alu_control = decode_code;
    stall       = 1'b0;
    mult_start  = 1'b0;
    mult_done   = 1'b0;
    if (state == BUSY) begin
      alu_control = C_MULT;
      if (!flush) begin
        stall     = ~cnt_zero;
        mult_done = cnt_zero;
      end
    end else begin
      mult_start = mult_issue;
      if (SINGLE_CYCLE) begin
        mult_done = mult_issue;
      end else begin
        stall = mult_issue;
      end
    end
  end

  // Sequencer state and cycle counter.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mult_issue && !SINGLE_CYCLE) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_zero) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Sticky record of any unflushed illegal R-type funct.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      illegal_seen <= 1'b0;
    end else if (illegal_op && !flush) begin
      illegal_seen <= 1'b1;
    end
  end

endmodule
